result_output_serializer: RTL and testbench

RESULT_OUTPUT_SERIALIZER -- requirements
Module: result_output_serializer

---
 rtl/result_output_serializer.sv | 100 ++++++++++
 tb/tb_result_output_serializer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/result_output_serializer.sv
// Serialises one result/status pair into two independent word-wide FIFO streams, upper half first.
// Optional RESULT_SKIP_ON_ERROR_EN: a nonzero latched status suppresses the result stream.
module result_output_serializer #(
  parameter int word_size = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_out,
  input  logic [2*word_size-1:0]   result_in,
  input  logic [2*word_size-1:0]   status_in,
  input  logic                     full_result,
  input  logic                     full_status,
  output logic                     wr_out_result,
  output logic                     wr_out_status,
  output logic [word_size-1:0]     data_out_result,
  output logic [word_size-1:0]     data_out_status,
  output logic                     busy,
  output logic                     done_out,
  output logic [7:0]               tx_count
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  // Word index value meaning "stream finished".
  localparam logic [1:0] IDX_END = 2'd2;

  state_t                   state, state_nxt;
  logic [2*word_size-1:0]   res_reg, stat_reg;
  logic [1:0]               res_idx, stat_idx, res_idx_nxt, stat_idx_nxt;
  logic                     skip_res;

`ifdef RESULT_SKIP_ON_ERROR_EN
  assign skip_res = |status_in;
`else
  assign skip_res = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    res_idx_nxt     = res_idx;
    stat_idx_nxt    = stat_idx;
    wr_out_result   = 1'b0;
    wr_out_status   = 1'b0;
    data_out_result = '0;
    data_out_status = '0;
    busy            = (state != IDLE);
    done_out        = 1'b0;
    case (state)
      IDLE: begin
        if (start_out) state_nxt = SEND;
      end
      SEND: begin
        if (res_idx != IDX_END && !full_result) begin
          wr_out_result   = 1'b1;
          data_out_result = (res_idx == 2'd0) ? res_reg[2*word_size-1:word_size]
                                              : res_reg[word_size-1:0];
          res_idx_nxt     = res_idx + 2'd1;
        end
        if (stat_idx != IDX_END && !full_status) begin
          wr_out_status   = 1'b1;
          data_out_status = (stat_idx == 2'd0) ? stat_reg[2*word_size-1:word_size]
                                               : stat_reg[word_size-1:0];
          stat_idx_nxt    = stat_idx + 2'd1;
        end
        // Leave SEND as soon as this cycle's writes complete both streams.
        if (res_idx_nxt == IDX_END && stat_idx_nxt == IDX_END) state_nxt = DONE;
      end
      DONE: begin
        done_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      res_reg  <= '0;
      stat_reg <= '0;
      res_idx  <= '0;
      stat_idx <= '0;
      tx_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_out) begin
        res_reg  <= result_in;
        stat_reg <= status_in;
        res_idx  <= skip_res ? IDX_END : 2'd0;
        stat_idx <= 2'd0;
      end else begin
        res_idx  <= res_idx_nxt;
        stat_idx <= stat_idx_nxt;
      end
      // Counted on entry to DONE so the new value is visible alongside done_out.
      if (state == SEND && state_nxt == DONE) tx_count <= tx_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_result_output_serializer.sv
// Scoreboard bench for result_output_serializer: driver pushes expected words, monitor pops on writes.
// Build with or without RESULT_SKIP_ON_ERROR_EN; the reference model follows the same macro.
module tb_result_output_serializer;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_out = 1'b0;
  logic [2*W-1:0] result_in = '0;
  logic [2*W-1:0] status_in = '0;
  logic          full_result = 1'b0;
  logic          full_status = 1'b0;
  logic          wr_out_result, wr_out_status;
  logic [W-1:0]  data_out_result, data_out_status;
  logic          busy, done_out;
  logic [7:0]    tx_count;

  result_output_serializer #(.word_size(W)) dut (
    .clk(clk), .rst(rst), .start_out(start_out),
    .result_in(result_in), .status_in(status_in),
    .full_result(full_result), .full_status(full_status),
    .wr_out_result(wr_out_result), .wr_out_status(wr_out_status),
    .data_out_result(data_out_result), .data_out_status(data_out_status),
    .busy(busy), .done_out(done_out), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_done = 0;
  int done_cyc = 0;
  logic [W-1:0] res_q[$];
  logic [W-1:0] stat_q[$];
  logic [7:0]   exp_cnt = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write must match the head of its stream's queue; idle data must be zero.
  always @(negedge clk) begin
    if (wr_out_result) begin
      if (res_q.size() == 0) check("extra_result_write", 32'(data_out_result), 32'hDEAD_BEEF);
      else check("result_word", 32'(data_out_result), 32'(res_q.pop_front()));
    end else check("result_data_idle_zero", 32'(data_out_result), 32'h0);
    if (wr_out_status) begin
      if (stat_q.size() == 0) check("extra_status_write", 32'(data_out_status), 32'hDEAD_BEEF);
      else check("status_word", 32'(data_out_status), 32'(stat_q.pop_front()));
    end else check("status_data_idle_zero", 32'(data_out_status), 32'h0);
    if (done_out) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  // Reference model: each value becomes upper half then lower half.
  task automatic push_expected(input logic [2*W-1:0] r, input logic [2*W-1:0] s);
    logic emit_res;
    emit_res = 1'b1;
`ifdef RESULT_SKIP_ON_ERROR_EN
    emit_res = (s == '0);
`endif
    if (emit_res) begin
      res_q.push_back(r[2*W-1:W]);
      res_q.push_back(r[W-1:0]);
    end
    stat_q.push_back(s[2*W-1:W]);
    stat_q.push_back(s[W-1:0]);
  endtask

  // One transaction. fr/fs: cycles after start during which full is held; rnd: random backpressure.
  task automatic do_pair(input logic [2*W-1:0] r, input logic [2*W-1:0] s,
                         input int fr, input int fs, input bit rnd, input bit junk, input int exp_lat);
    int t0, d0, k;
    @(posedge clk); #1;
    start_out = 1'b1; result_in = r; status_in = s;
    full_result = 1'b0; full_status = 1'b0;
    push_expected(r, s);
    t0 = cyc;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < 60) begin
      @(posedge clk); #1;
      k++;
      start_out = junk && (k == 1);
      if (junk) begin result_in = '1; status_in = '1; end
      full_result = rnd ? ($urandom_range(0, 2) == 0) : (k <= fr);
      full_status = rnd ? ($urandom_range(0, 2) == 0) : (k <= fs);
    end
    start_out = 1'b0; full_result = 1'b0; full_status = 1'b0;
    if (n_done == d0) check("done_timeout", 32'(k), 32'hFFFF);
    else begin
      exp_cnt = exp_cnt + 8'd1;
      if (exp_lat > 0) check("done_latency", 32'(done_cyc - t0), 32'(exp_lat));
      check("tx_count", 32'(tx_count), 32'(exp_cnt));
      check("result_words_left", 32'(res_q.size()), 32'h0);
      check("status_words_left", 32'(stat_q.size()), 32'h0);
    end
    @(posedge clk); #1;
    check("single_done", 32'(n_done - d0), 32'h1);
    check("busy_after_done", 32'(busy), 32'h0);
  endtask

  initial begin
    #12;
    check("rst_wr_result", 32'(wr_out_result), 32'h0);
    check("rst_wr_status", 32'(wr_out_status), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done_out), 32'h0);
    check("rst_tx_count", 32'(tx_count), 32'h0);
    @(negedge clk); rst = 1'b1;

    do_pair(32'h1234ABCD, 32'h0, 0, 0, 1'b0, 1'b0, 3);
    do_pair(32'h5555AAAA, 32'h0, 4, 0, 1'b0, 1'b0, 7);
    do_pair(32'h0BAD_F00D, 32'h0, 0, 0, 1'b0, 1'b1, 3);

    // Reset after the first result word has been written.
    @(posedge clk); #1;
    start_out = 1'b1; result_in = 32'h1111_2222; status_in = 32'h0;
    push_expected(32'h1111_2222, 32'h0);
    @(posedge clk); #1;
    start_out = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    res_q.delete(); stat_q.delete();
    exp_cnt = 8'd0;
    check("mid_rst_wr_result", 32'(wr_out_result), 32'h0);
    check("mid_rst_wr_status", 32'(wr_out_status), 32'h0);
    check("mid_rst_data_result", 32'(data_out_result), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_tx_count", 32'(tx_count), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_busy", 32'(busy), 32'h0);

    do_pair(32'h0000_0005, 32'h0000_0002, 0, 0, 1'b0, 1'b0, 3);

    for (int i = 0; i < 255; i++) begin
      logic [2*W-1:0] r, s;
      r = $urandom;
      s = ($urandom_range(0, 1) == 0) ? '0 : 2*W'($urandom);
      do_pair(r, s, 0, 0, 1'b1, ($urandom_range(0, 3) == 0), 0);
    end
    check("tx_count_wrap", 32'(tx_count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
